// File: rtl/fft_reorder.sv
// Ping-pong reorder buffer placed in front of an FFT datapath.
// Each frame is written in natural order into one bank. It is then read
// back from that bank in bit-reversed, radix-4 digit-reversed or natural
// order, while the other bank fills. Frame size and mode are latched per
// bank at the first write of a frame.
module fft_reorder #(
  parameter int KMAX = 10,
  parameter int DW   = 32,
  parameter int LW   = $clog2(KMAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [LW-1:0] cfg_log2n_i,
  input  logic [1:0]    cfg_mode_i,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          ready_o,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic          last_o,
  input  logic          ready_i,
  output logic [1:0]    bank_full_o
);

  localparam int            DEPTH = 2 ** KMAX;
  localparam int            IW    = (KMAX > 1) ? $clog2(KMAX) : 1;
  localparam logic [LW-1:0] LMAX  = LW'(KMAX);

  logic [DW-1:0]   mem [2][DEPTH];
  logic [1:0]      full;
  logic [LW-1:0]   len_b [2];
  logic [1:0]      mode_b [2];
  logic [KMAX-1:0] wr_cnt, rd_cnt;
  logic            wr_bank, rd_bank;

  logic            wr_en, wr_last, rd_load, rd_last;
  logic [LW-1:0]   cfg_len, wr_len;
  logic [KMAX-1:0] rd_addr;

  // Mask with the low l bits set; equals the index of the last sample of a frame.
  function automatic logic [KMAX-1:0] len_mask(input logic [LW-1:0] l);
    logic [KMAX-1:0] m;
    m = '0;
    for (int i = 0; i < KMAX; i++) m[i] = (i < int'(l));
    return m;
  endfunction

  // Permuted read address; bits at or above l are always zero.
  function automatic logic [KMAX-1:0] perm_addr(input logic [KMAX-1:0] cnt,
                                                input logic [LW-1:0] l,
                                                input logic [1:0] mode);
    logic [KMAX-1:0] a;
    logic [IW-1:0]   src;
    int              n;
    a   = '0;
    src = '0;
    n   = int'(l);
    if (mode[1]) begin
      a = cnt & len_mask(l);
    end else if (mode[0] && !l[0]) begin
      // Digit d (bits 2d+1:2d) takes digit n/2-1-d of the counter.
      for (int i = 0; i < KMAX; i++) begin
        if (i < n) begin
          src  = IW'(n - 2 - (i & ~1) + (i & 1));
          a[i] = cnt[src];
        end
      end
    end else begin
      // Mode 0, and mode 1 with an odd size, use plain bit reversal.
      for (int i = 0; i < KMAX; i++) begin
        if (i < n) begin
          src  = IW'(n - 1 - i);
          a[i] = cnt[src];
        end
      end
    end
    return a;
  endfunction

  assign ready_o     = !full[wr_bank];
  assign bank_full_o = full;
  assign wr_en       = valid_i && ready_o;
  assign cfg_len     = (cfg_log2n_i > LMAX) ? LMAX : cfg_log2n_i;
  assign wr_len      = (wr_cnt == '0) ? cfg_len : len_b[wr_bank];
  assign wr_last     = (wr_cnt == len_mask(wr_len));
  assign rd_load     = full[rd_bank] && (!valid_o || ready_i);
  assign rd_last     = (rd_cnt == len_mask(len_b[rd_bank]));
  assign rd_addr     = perm_addr(rd_cnt, len_b[rd_bank], mode_b[rd_bank]);

  // Sample storage: natural-order writes, no reset so contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_bank][wr_cnt] <= data_i;
  end

  // Write counter, read counter, bank status and output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full      <= '0;
      len_b[0]  <= '0;
      len_b[1]  <= '0;
      mode_b[0] <= '0;
      mode_b[1] <= '0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      valid_o   <= 1'b0;
      data_o    <= '0;
      last_o    <= 1'b0;
    end else begin
      // The write and read banks can never be the same bank here: a write
      // needs the bank EMPTY, a read needs it FULL.
      if (wr_en) begin
        if (wr_cnt == '0) begin
          len_b[wr_bank]  <= cfg_len;
          mode_b[wr_bank] <= cfg_mode_i;
        end
        if (wr_last) begin
          full[wr_bank] <= 1'b1;
          wr_cnt        <= '0;
          wr_bank       <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + KMAX'(1);
        end
      end
      if (rd_load) begin
        valid_o <= 1'b1;
        data_o  <= mem[rd_bank][rd_addr];
        last_o  <= rd_last;
        if (rd_last) begin
          full[rd_bank] <= 1'b0;
          rd_cnt        <= '0;
          rd_bank       <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + KMAX'(1);
        end
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed and randomised checks of the fft_reorder ping-pong buffer.
module tb_fft_reorder;
  localparam int KMAX = 4;
  localparam int DW   = 32;
  localparam int LW   = 3;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic [LW-1:0] cfg_log2n_i = '0;
  logic [1:0]    cfg_mode_i = '0;
  logic          valid_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          ready_o, valid_o, last_o;
  logic          ready_i = 1'b1;
  logic [DW-1:0] data_o;
  logic [1:0]    bank_full_o;

  fft_reorder #(.KMAX(KMAX), .DW(DW), .LW(LW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_log2n_i(cfg_log2n_i), .cfg_mode_i(cfg_mode_i),
    .valid_i(valid_i), .data_i(data_i), .ready_o(ready_o), .valid_o(valid_o),
    .data_o(data_o), .last_o(last_o), .ready_i(ready_i), .bank_full_o(bank_full_o)
  );

  always #5 clk_i = ~clk_i;

  int tests = 0;
  int fails = 0;
  int total = 0;
  bit rand_done = 0;
  int got_d[$];
  bit got_l[$];
  int exp_d[$];
  bit exp_l[$];

  typedef struct {
    int l;
    int mode;
    int base;
    int flen;
    int dexp[16];
  } vec_t;
  vec_t vt[10];

  // Inputs change just after the rising edge, so a transfer at the next edge
  // is decided by what is seen on the falling edge.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o && ready_i) begin
      got_d.push_back(int'(data_o));
      got_l.push_back(last_o);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic int ref_idx(input int l, input int m, input int k);
    int le;
    int r;
    int x;
    le = (l > KMAX) ? KMAX : l;
    r  = 0;
    x  = k;
    if (m >= 2) return k;
    if (m == 1 && (le % 2) == 0) begin
      for (int d = 0; d < le / 2; d++) begin
        r = (r << 2) | (x & 3);
        x = x >> 2;
      end
    end else begin
      for (int b = 0; b < le; b++) begin
        r = (r << 1) | (x & 1);
        x = x >> 1;
      end
    end
    return r;
  endfunction

  task automatic put(input int d, input int l, input int m, input bit first);
    bit acc;
    bit ok;
    ok = 0;
    valid_i = 1'b1;
    data_i  = DW'(d);
    if (first) begin
      cfg_log2n_i = LW'(l);
      cfg_mode_i  = 2'(m);
    end else begin
      cfg_log2n_i = LW'($urandom_range(0, 7));
      cfg_mode_i  = 2'($urandom_range(0, 3));
    end
    for (int t = 0; t < 300; t++) begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL put_timeout: got no accept expected accept of %0d", d);
    end
  endtask

  task automatic drive_frame(input int l, input int m, input int din[16], input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          valid_i = 1'b0;
          @(posedge clk_i);
          #1;
        end
      end
      put(din[i], l, m, i == 0);
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_out(input int n, input string nm, output bit ok);
    ok = 0;
    for (int t = 0; t < 5000; t++) begin
      if (got_d.size() >= n) begin
        ok = 1;
        break;
      end
      @(posedge clk_i);
      #1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d outputs expected %0d", nm, got_d.size(), n);
    end
  endtask

  task automatic check_frame(input string nm, input int n, input int flen, input int dexp[16]);
    bit ok;
    int d;
    bit l;
    wait_out(n, nm, ok);
    if (ok) begin
      for (int k = 0; k < n; k++) begin
        d = got_d.pop_front();
        l = got_l.pop_front();
        chk($sformatf("%s_data[%0d]", nm, k), 64'(d), 64'(dexp[k]));
        chk($sformatf("%s_last[%0d]", nm, k), 64'(l), 64'(((k + 1) % flen) == 0));
      end
    end
  endtask

  task automatic reset_pulse(input string nm);
    #2 rst_i = 1'b1;
    #1;
    chk({nm, "_valid"}, 64'(valid_o), 64'(0));
    chk({nm, "_data"}, 64'(data_o), 64'(0));
    chk({nm, "_last"}, 64'(last_o), 64'(0));
    chk({nm, "_full"}, 64'(bank_full_o), 64'(0));
    chk({nm, "_ready"}, 64'(ready_o), 64'(1));
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    got_d.delete();
    got_l.delete();
    ready_i = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int din[16];
    int dx[16];
    int n, l, m;
    bit ok;

    vt[0] = '{3, 0, 0, 8, '{0,4,2,6,1,5,3,7,0,0,0,0,0,0,0,0}};
    vt[1] = '{4, 1, 0, 16, '{0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15}};
    vt[2] = '{3, 1, 0, 8, '{0,4,2,6,1,5,3,7,0,0,0,0,0,0,0,0}};
    vt[3] = '{2, 2, 10, 4, '{10,11,12,13,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[4] = '{0, 2, 99, 1, '{99,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[5] = '{2, 3, 20, 4, '{20,21,22,23,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[6] = '{5, 0, 0, 16, '{0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15}};
    vt[7] = '{2, 1, 30, 4, '{30,31,32,33,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[8] = '{1, 0, 5, 2, '{5,6,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vt[9] = '{4, 0, 100, 16, '{100,108,104,112,102,110,106,114,101,109,105,113,103,111,107,115}};

    // Reset values
    #1;
    chk("rst_valid", 64'(valid_o), 64'(0));
    chk("rst_data", 64'(data_o), 64'(0));
    chk("rst_last", 64'(last_o), 64'(0));
    chk("rst_full", 64'(bank_full_o), 64'(0));
    chk("rst_ready", 64'(ready_o), 64'(1));
    #12 rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // First-output latency after the last write
    for (int i = 0; i < 16; i++) din[i] = i;
    drive_frame(3, 0, din, 8, 0);
    chk("lat_valid_t", 64'(valid_o), 64'(0));
    chk("lat_full_t", 64'(bank_full_o), 64'(1));
    @(posedge clk_i);
    #1;
    chk("lat_valid_t1", 64'(valid_o), 64'(1));
    chk("lat_data_t1", 64'(data_o), 64'(0));
    check_frame("lat", 8, 8, vt[0].dexp);

    // Table of directed frames
    for (int v = 0; v < 10; v++) begin
      for (int i = 0; i < 16; i++) din[i] = vt[v].base + i;
      drive_frame(vt[v].l, vt[v].mode, din, vt[v].flen, 0);
      check_frame($sformatf("vec%0d", v), vt[v].flen, vt[v].flen, vt[v].dexp);
    end

    // Both banks fill while downstream stalls
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) din[i] = i;
    drive_frame(3, 0, din, 8, 0);
    for (int i = 0; i < 8; i++) din[i] = 8 + i;
    drive_frame(3, 0, din, 8, 0);
    chk("stall_ready", 64'(ready_o), 64'(0));
    chk("stall_full", 64'(bank_full_o), 64'(3));
    chk("stall_valid", 64'(valid_o), 64'(1));
    chk("stall_data", 64'(data_o), 64'(0));
    repeat (3) @(posedge clk_i);
    #1;
    chk("stall_hold_data", 64'(data_o), 64'(0));
    chk("stall_hold_valid", 64'(valid_o), 64'(1));
    chk("stall_hold_ready", 64'(ready_o), 64'(0));
    ready_i = 1'b1;
    dx = '{0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15};
    check_frame("stall", 16, 8, dx);
    repeat (2) @(posedge clk_i);
    #1;
    chk("stall_ready_after", 64'(ready_o), 64'(1));
    chk("stall_extra", 64'(got_d.size()), 64'(0));

    // Random valid/ready over 20 mixed frames
    total = 0;
    rand_done = 0;
    fork
      begin
        for (int f = 0; f < 20; f++) begin
          l = $urandom_range(0, 5);
          m = $urandom_range(0, 3);
          n = 1 << ((l > KMAX) ? KMAX : l);
          for (int i = 0; i < 16; i++) din[i] = $urandom_range(0, 65535);
          for (int k = 0; k < n; k++) begin
            exp_d.push_back(din[ref_idx(l, m, k)]);
            exp_l.push_back(k == n - 1);
          end
          total += n;
          drive_frame(l, m, din, n, 1);
        end
        rand_done = 1;
      end
      begin
        for (int t = 0; t < 20000; t++) begin
          if (rand_done && got_d.size() >= total) break;
          @(posedge clk_i);
          #1;
          ready_i = 1'($urandom_range(0, 1));
        end
        ready_i = 1'b1;
      end
    join
    wait_out(total, "rand", ok);
    if (ok) begin
      chk("rand_count", 64'(got_d.size()), 64'(total));
      for (int k = 0; k < total; k++) begin
        chk($sformatf("rand_data[%0d]", k), 64'(got_d.pop_front()), 64'(exp_d[k]));
        chk($sformatf("rand_last[%0d]", k), 64'(got_l.pop_front()), 64'(exp_l[k]));
      end
    end
    got_d.delete();
    got_l.delete();

    // Reset mid-fill
    ready_i = 1'b0;
    for (int i = 0; i < 16; i++) din[i] = 40 + i;
    drive_frame(3, 0, din, 8, 0);
    for (int i = 0; i < 3; i++) put(60 + i, 3, 0, i == 0);
    reset_pulse("rfill");

    // Reset mid-drain
    for (int i = 0; i < 16; i++) din[i] = 50 + i;
    drive_frame(3, 0, din, 8, 0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_pulse("rdrain");

    // First frame after reset
    for (int i = 0; i < 16; i++) din[i] = i;
    drive_frame(2, 0, din, 4, 0);
    dx = '{0,2,1,3,0,0,0,0,0,0,0,0,0,0,0,0};
    check_frame("post_rst", 4, 4, dx);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Parametrised FFT reorder buffer that converts natural-order sample streams into bit-reversed (radix-2), digit-reversed (radix-4) or unchanged (natural) order. The FFT size and reorder mode are selected per frame at run time. The block sits between the sample source and the FFT datapath in the user domain. It uses two ping-pong banks, with full valid/ready back-pressure on both sides.

## Interface
- KMAX, 10, log2 of the maximum frame length; each bank is 2^KMAX words deep
- DW, 32, data width
- LW, $clog2(KMAX+1), width of the size-configuration field
- clk_i  in  1  single clock; all logic is on its rising edge
- rst_i  in  1  reset, asynchronous and active-high
- cfg_log2n_i  in  LW  log2 of the frame length L, sampled at each frame start
- cfg_mode_i  in  2  reorder mode, sampled at each frame start: 0 = bit-reverse, 1 = radix-4 digit-reverse, 2 and 3 = natural order
- valid_i  in  1  input sample valid
- data_i  in  DW  input sample
- ready_o  out  1  input sample can be accepted
- valid_o  out  1  output sample valid
- data_o  out  DW  output sample
- last_o  out  1  marks the final sample of an output frame
- ready_i  in  1  downstream ready
- bank_full_o  out  2  per-bank FULL status, for debug and monitoring

## Operation
- Storage:
  - Two banks of 2^KMAX x DW; memory reads are asynchronous.
  - Each bank holds a state bit, EMPTY or FULL, plus latched config fields L_b and mode_b.
- Write side:
  - A write occurs when valid_i && ready_o.
  - ready_o = !full[wr_bank]. It is derived only from registered state, with no path from ready_i.
  - When wr_cnt == 0, cfg_log2n_i and cfg_mode_i are latched into the bank at the same edge as the first write.
  - L is clamped to KMAX when cfg_log2n_i > KMAX.
  - Sample wr_cnt is written to natural address wr_cnt.
  - When wr_cnt == 2^L - 1 (L = 0 means a 1-sample frame):
    - full[wr_bank] is set;
    - wr_cnt returns to 0;
    - wr_bank toggles.
- Read address, for L = L_b(rd_bank):
  - Mode 0: the low L bits of rd_cnt are reversed.
  - Mode 1 with even L: the base-4 digits of the low L bits are reversed.
  - Mode 1 with odd L: falls back to mode 0.
  - Modes 2 and 3: the address equals rd_cnt.
  - Bits above L are zero in every mode.
- Read side:
  - The output register {data_o, last_o} loads when full[rd_bank] && (!valid_o || ready_i).
  - On load: valid_o is set, and last_o = (rd_cnt == 2^L - 1).
  - On the last fetch of a bank: full[rd_bank] clears, rd_cnt returns to 0 and rd_bank toggles, all at the same edge.
  - If no load occurs and ready_i is high, valid_o clears.
  - data_o and last_o are held stable while valid_o && !ready_i.
- Invariants:
  - A bank is never read while it is being filled.
  - Data is never overwritten before it has been fetched.
  - The block never drops or duplicates a sample.

## Timing
- Reset values:
  - Outputs: valid_o = 0, data_o = 0, last_o = 0, bank_full_o = 0, ready_o = 1.
  - Internal state: wr_cnt = 0, rd_cnt = 0, wr_bank = 0, rd_bank = 0, both banks EMPTY.
- Reset mid-operation: a partial frame is discarded and the banks are not zeroed. The first post-reset frame starts at wr_cnt = 0 with fresh config.
- Latency: if the last sample of a frame is accepted at edge t, its bank is FULL after t, the first output is loaded at t+1, and valid_o is high in the cycle after t+1.
- Throughput:
  - One sample per cycle on each side when nothing stalls.
  - Consecutive frames drain with no bubble while the next bank is already FULL.
- Both banks FULL: ready_o = 0. It returns to 1 in the cycle after the edge where the reader frees wr_bank.
- Simultaneous events:
  - A write completing bank A and a read finishing bank B at the same edge are independent.
  - A bank freed at edge t can accept its first write at edge t+1, not at t.
- Config: a change to cfg_* in mid-frame has no effect until the next frame start. Each bank drains with its own latched L_b and mode_b.

## Test plan
- KMAX=4, mode 0, L=3, inputs 0..7, ready_i held high:
  - output order 0,4,2,6,1,5,3,7;
  - last_o on value 7;
  - valid_o high in the cycle after the edge following the last input edge.
- KMAX=4, mode 1, L=4, inputs 0..15: output order 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15. Mode 1 with L=3 reproduces the mode 0 order.
- Mode 2, L=2, inputs 10,11,12,13: outputs 10,11,12,13. Then a frame with L=0 and input 99: single output 99 with last_o = 1.
- Continuous input of frames 0..7 and 8..15 (L=3, mode 0) with ready_i held low:
  - ready_o drops after 16 accepted samples;
  - bank_full_o = 2'b11;
  - data_o is held stable;
  - after ready_i rises, all 16 outputs arrive in order with no loss or duplicate.
- Random valid_i/ready_i toggling over 20 frames of mixed L in {0..4} and modes: a scoreboard matches every sample against the reference permutation, and last_o aligns with frame ends.
- Assert rst_i asynchronously mid-fill, then mid-drain: all outputs return to their reset values immediately, and the next frame (L=2, inputs 0..3, mode 0) outputs 0,2,1,3.
